// File: rtl/laplace_filter_param.sv
// 3x3 neighbourhood filter (Laplace-8 / Laplace-4 / box / pass) over a streamed
// 3-pixel column window, with per-line mode latch, line-start priming and ready/valid flow.
module laplace_filter_param #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = DATA_W + 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_mode,
    input  logic              i_sol,
    input  logic [DATA_W-1:0] i_pixel_1,
    input  logic [DATA_W-1:0] i_pixel_2,
    input  logic [DATA_W-1:0] i_pixel_3,
    input  logic              i_pixel_valid,
    output logic              o_pixel_ready,
    output logic              o_pixel_valid,
    input  logic              i_pixel_ready,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_sat
);
    localparam int STAGES = 3;
    localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'({DATA_W{1'b1}});

    typedef struct packed {
        logic [DATA_W-1:0] top;
        logic [DATA_W-1:0] mid;
        logic [DATA_W-1:0] bot;
    } col_t;

    logic [STAGES-1:0] vld_pipe;
    logic              en, accept;
    col_t              col_in;
    col_t [2:0]        win;
    logic [1:0]        prime_cnt, prime_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [1:0]        s1_mode, s2_mode;
    logic [ACC_W-1:0]  s2_pos, s2_neg;

    assign en            = ~vld_pipe[STAGES-1] | i_pixel_ready;
    assign accept        = i_pixel_valid & en;
    assign o_pixel_ready = en;
    assign o_pixel_valid = vld_pipe[STAGES-1];
    assign col_in        = '{top: i_pixel_1, mid: i_pixel_2, bot: i_pixel_3};

    // Priming count stays at 0 until the first i_sol, so unframed columns never emit.
    always_comb begin
        prime_nxt = prime_cnt;
        mode_nxt  = mode_q;
        if (accept) begin
            if (i_sol) begin
                prime_nxt = 2'd1;
                mode_nxt  = i_mode;
            end else if (prime_cnt != 2'd0 && prime_cnt != 2'd3) begin
                prime_nxt = prime_cnt + 2'd1;
            end
        end
    end

    // S1: window shift, priming and per-pixel mode tag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prime_cnt   <= '0;
            mode_q      <= '0;
            win         <= '0;
            s1_mode     <= '0;
            vld_pipe[0] <= 1'b0;
        end else begin
            prime_cnt <= prime_nxt;
            mode_q    <= mode_nxt;
            if (en) begin
                vld_pipe[0] <= accept && (prime_nxt == 2'd3);
                if (accept) begin
                    win     <= {col_in, win[2], win[1]};
                    s1_mode <= mode_nxt;
                end
            end
        end
    end

    // S2: neighbourhood sums, reduced to a positive and a negative term per mode
    logic [ACC_W-1:0] xc, xn, xs, xe, xw, xnw, xsw, xne, xse;
    logic [ACC_W-1:0] sum4, sum8, pos_c, neg_c;

    assign xc  = ACC_W'(win[1].mid);
    assign xn  = ACC_W'(win[1].top);
    assign xs  = ACC_W'(win[1].bot);
    assign xe  = ACC_W'(win[2].mid);
    assign xw  = ACC_W'(win[0].mid);
    assign xnw = ACC_W'(win[0].top);
    assign xsw = ACC_W'(win[0].bot);
    assign xne = ACC_W'(win[2].top);
    assign xse = ACC_W'(win[2].bot);
    assign sum4 = xn + xs + xe + xw;
    assign sum8 = sum4 + xnw + xsw + xne + xse;

    always_comb begin
        pos_c = xc;
        neg_c = '0;
        case (s1_mode)
            2'd0: begin pos_c = xc << 3; neg_c = sum8; end
            2'd1: begin pos_c = xc << 2; neg_c = sum4; end
            2'd2: begin pos_c = sum8 + xc; neg_c = '0; end
            default: begin pos_c = xc; neg_c = '0; end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe[1] <= 1'b0;
            s2_pos      <= '0;
            s2_neg      <= '0;
            s2_mode     <= '0;
        end else if (en) begin
            vld_pipe[1] <= vld_pipe[0];
            s2_pos      <= pos_c;
            s2_neg      <= neg_c;
            s2_mode     <= s1_mode;
        end
    end

    // S3: magnitude, normalising shift and clamp
    logic [ACC_W-1:0] diff, res;
    logic [1:0]       sh;

    always_comb begin
        diff = (s2_pos >= s2_neg) ? (s2_pos - s2_neg) : (s2_neg - s2_pos);
        case (s2_mode)
            2'd1:    sh = 2'd2;
            2'd3:    sh = 2'd0;
            default: sh = 2'd3;
        endcase
        res = diff >> sh;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe[2] <= 1'b0;
            o_pixel     <= '0;
            o_sat       <= 1'b0;
        end else if (en) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                o_pixel <= (res > PIX_MAX) ? PIX_MAX[DATA_W-1:0] : res[DATA_W-1:0];
                o_sat   <= (res > PIX_MAX);
            end
        end
    end
endmodule

// File: tb/tb_laplace_filter_param.sv
// Directed bench for laplace_filter_param: per-scenario tasks with inline checks.
module tb_laplace_filter_param;
    localparam int DATA_W = 8;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [1:0]        i_mode;
    logic              i_sol;
    logic [DATA_W-1:0] i_pixel_1, i_pixel_2, i_pixel_3;
    logic              i_pixel_valid;
    logic              o_pixel_ready;
    logic              o_pixel_valid;
    logic              i_pixel_ready;
    logic [DATA_W-1:0] o_pixel;
    logic              o_sat;

    laplace_filter_param #(.DATA_W(DATA_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_sol(i_sol),
        .i_pixel_1(i_pixel_1), .i_pixel_2(i_pixel_2), .i_pixel_3(i_pixel_3),
        .i_pixel_valid(i_pixel_valid), .o_pixel_ready(o_pixel_ready),
        .o_pixel_valid(o_pixel_valid), .i_pixel_ready(i_pixel_ready),
        .o_pixel(o_pixel), .o_sat(o_sat)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [8:0] outq[$];
    int         stampq[$];

    always @(posedge i_clk) cycle <= cycle + 1;

    // Consumed outputs, sampled mid-cycle: {o_sat, o_pixel} plus cycle stamp
    always @(negedge i_clk)
        if (i_rst_n && o_pixel_valid && i_pixel_ready) begin
            outq.push_back({o_sat, o_pixel});
            stampq.push_back(cycle);
        end

    task automatic drive_col(input logic [23:0] col, input logic sol, input logic [1:0] mode);
        logic acc;
        acc = 1'b0;
        {i_pixel_1, i_pixel_2, i_pixel_3} = col;
        i_sol = sol; i_mode = mode; i_pixel_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge i_clk); acc = o_pixel_ready;
            @(posedge i_clk); #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: column %h not accepted within 50 cycles", col);
        end
    endtask

    task automatic idle(input int n);
        i_pixel_valid = 1'b0; i_sol = 1'b0;
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic prime2(input logic [23:0] a, input logic [23:0] b, input logic [1:0] mode);
        outq.delete(); stampq.delete();
        drive_col(a, 1'b1, mode);
        drive_col(b, 1'b0, mode);
        idle(6);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_pixel_valid); end
        checks++; if (o_pixel !== 8'd0) begin errors++; $display("FAIL reset_pixel: got %0d want 0", o_pixel); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", o_sat); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++; if (o_pixel_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_pixel_ready); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_flat;
        logic [7:0] exp [4];
        exp = '{8'd0, 8'd0, 8'd112, 8'd100};
        for (int m = 0; m < 4; m++) begin
            prime2(24'h646464, 24'h646464, 2'(m));
            checks++; if (outq.size() != 0) begin errors++; $display("FAIL flat_prime m%0d: got %0d outputs want 0", m, outq.size()); end
            drive_col(24'h646464, 1'b0, 2'(m));
            idle(6);
            checks++;
            if (outq.size() != 1) begin errors++; $display("FAIL flat_count m%0d: got %0d outputs want 1", m, outq.size()); end
            else if (outq[0] !== {1'b0, exp[m]}) begin errors++; $display("FAIL flat_value m%0d: got %h want %h", m, outq[0], {1'b0, exp[m]}); end
        end
    endtask

    task automatic test_centre;
        logic [23:0] mid [3];
        logic [1:0]  md  [3];
        logic [8:0]  exp [3];
        mid = '{24'h00FF00, 24'h00FF00, 24'hC80000};
        md  = '{2'd0, 2'd1, 2'd0};
        exp = '{9'h0FF, 9'h0FF, 9'd25};
        for (int k = 0; k < 3; k++) begin
            prime2(24'h0, mid[k], md[k]);
            drive_col(24'h0, 1'b0, md[k]);
            idle(6);
            checks++;
            if (outq.size() != 1) begin errors++; $display("FAIL centre_count %0d: got %0d outputs want 1", k, outq.size()); end
            else if (outq[0] !== exp[k]) begin errors++; $display("FAIL centre_value %0d: got %h want %h", k, outq[0], exp[k]); end
        end
    endtask

    task automatic test_saturation;
        prime2(24'hFFFFFF, 24'hFFFFFF, 2'd2);
        drive_col(24'hFFFFFF, 1'b0, 2'd2);
        idle(6);
        checks++;
        if (outq.size() != 1) begin errors++; $display("FAIL sat_count: got %0d outputs want 1", outq.size()); end
        else if (outq[0] !== 9'h1FF) begin errors++; $display("FAIL sat_value: got %h want 1ff", outq[0]); end
    endtask

    task automatic test_back_to_back;
        localparam int N = 12;
        logic [23:0] cols [N];
        logic [8:0]  exp  [N-2];
        int          sum;
        for (int k = 0; k < N; k++)
            cols[k] = {8'(10*k), 8'(255-7*k), 8'(3*k+20)};
        for (int k = 2; k < N; k++) begin
            sum = 0;
            for (int j = k-2; j <= k; j++)
                sum += int'(cols[j][23:16]) + int'(cols[j][15:8]) + int'(cols[j][7:0]);
            sum = sum >> 3;
            exp[k-2] = (sum > 255) ? 9'h1FF : {1'b0, 8'(sum)};
        end
        outq.delete(); stampq.delete();
        fork
            begin
                for (int k = 0; k < N; k++) drive_col(cols[k], k == 0, 2'd2);
                idle(8);
            end
            begin
                logic [7:0] held;
                int w;
                w = 0;
                while (outq.size() < 2 && w < 100) begin @(posedge i_clk); #1; w++; end
                checks++; if (outq.size() < 2) begin errors++; $display("FAIL stall_wait: got %0d outputs want >=2", outq.size()); end
                i_pixel_ready = 1'b0;
                held = o_pixel;
                repeat (5) begin
                    @(negedge i_clk);
                    checks++; if (o_pixel_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", o_pixel_ready); end
                    checks++; if (o_pixel !== held) begin errors++; $display("FAIL stall_hold: got %0d want %0d", o_pixel, held); end
                    @(posedge i_clk); #1;
                end
                i_pixel_ready = 1'b1;
            end
        join
        checks++;
        if (outq.size() != N-2) begin errors++; $display("FAIL stream_count: got %0d want %0d", outq.size(), N-2); end
        else begin
            for (int k = 0; k < N-2; k++) begin
                checks++;
                if (outq[k] !== exp[k]) begin errors++; $display("FAIL stream_value %0d: got %h want %h", k, outq[k], exp[k]); end
            end
            checks++;
            if (stampq[N-3] - stampq[0] != N-3+5) begin
                errors++; $display("FAIL stream_throughput: span %0d want %0d", stampq[N-3] - stampq[0], N-3+5);
            end
        end
    endtask

    task automatic test_mode_change;
        outq.delete(); stampq.delete();
        drive_col(24'h646464, 1'b1, 2'd0);
        for (int k = 0; k < 4; k++) drive_col(24'h646464, 1'b0, 2'd2);
        idle(6);
        checks++;
        if (outq.size() != 3) begin errors++; $display("FAIL mode_hold_count: got %0d want 3", outq.size()); end
        else for (int k = 0; k < 3; k++) begin
            checks++;
            if (outq[k] !== 9'd0) begin errors++; $display("FAIL mode_hold_value %0d: got %h want 000", k, outq[k]); end
        end
        prime2(24'h646464, 24'h646464, 2'd2);
        checks++; if (outq.size() != 0) begin errors++; $display("FAIL mode_reprime: got %0d outputs want 0", outq.size()); end
        drive_col(24'h646464, 1'b0, 2'd2);
        idle(6);
        checks++;
        if (outq.size() != 1) begin errors++; $display("FAIL mode_new_count: got %0d want 1", outq.size()); end
        else if (outq[0] !== 9'd112) begin errors++; $display("FAIL mode_new_value: got %h want 070", outq[0]); end
    endtask

    task automatic test_reset_mid;
        int w;
        i_pixel_ready = 1'b0;
        drive_col(24'h003200, 1'b1, 2'd3);
        drive_col(24'h003200, 1'b0, 2'd3);
        drive_col(24'h003200, 1'b0, 2'd3);
        idle(0);
        w = 0;
        while (!o_pixel_valid && w < 20) begin @(posedge i_clk); #1; w++; end
        checks++; if (o_pixel_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got %b want 1", o_pixel_valid); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_pixel_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", o_pixel_valid); end
        checks++; if (o_pixel !== 8'd0) begin errors++; $display("FAIL rstmid_pixel: got %0d want 0", o_pixel); end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_pixel_ready = 1'b1;
        outq.delete(); stampq.delete();
        for (int k = 0; k < 3; k++) drive_col(24'h004D00, 1'b0, 2'd3);
        idle(6);
        checks++; if (outq.size() != 0) begin errors++; $display("FAIL rstmid_nosol: got %0d outputs want 0", outq.size()); end
        prime2(24'h004D00, 24'h004D00, 2'd3);
        checks++; if (outq.size() != 0) begin errors++; $display("FAIL rstmid_prime: got %0d outputs want 0", outq.size()); end
        drive_col(24'h004D00, 1'b0, 2'd3);
        idle(6);
        checks++;
        if (outq.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", outq.size()); end
        else if (outq[0] !== 9'd77) begin errors++; $display("FAIL rstmid_value: got %h want 04d", outq[0]); end
    endtask

    initial begin
        i_rst_n = 1'b0; i_mode = 2'd0; i_sol = 1'b0;
        i_pixel_1 = '0; i_pixel_2 = '0; i_pixel_3 = '0;
        i_pixel_valid = 1'b0; i_pixel_ready = 1'b1;
        test_reset();
        test_flat();
        test_centre();
        test_saturation();
        test_back_to_back();
        test_mode_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
